// File: rtl/mips_control_unit.sv
// Multi-cycle MIPS-style control unit.
// Walks FETCH -> DECODE -> EXEC [-> MEM [-> WB]] for each instruction and
// decodes the datapath strobes from the current state and opcode. HALT is
// terminal until reset. A 16-bit counter tracks retired instructions.
module mips_control_unit #(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BUS_WIDTH-1:0] instruction,
  input  logic                 zero_flag,
  output logic                 InsRead,
  output logic                 PCnext,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 ALUSrc,
  output logic                 RegWrite,
  output logic                 outEn,
  output logic [1:0]           RegDst,
  output logic [1:0]           PCSrc,
  output logic [1:0]           MemtoReg,
  output logic [2:0]           ALUControl,
  output logic                 halted,
  output logic [15:0]          retired
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_BNE   = 4'h5;
  localparam logic [3:0] OP_J     = 4'h6;
  localparam logic [3:0] OP_JR    = 4'h7;
  localparam logic [3:0] OP_IN    = 4'h8;
  localparam logic [3:0] OP_OUT   = 4'h9;
  localparam logic [3:0] OP_JAL   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t     state;
  logic [3:0] opcode;
  logic [2:0] funct;
  logic       unused_bits;

  assign opcode      = instruction[15:12];
  assign funct       = instruction[2:0];
  // Only the opcode and funct fields steer control; the rest feeds the datapath.
  assign unused_bits = ^instruction;

  // Output decode. It is combinational so that zero_flag steers PCSrc within
  // the EXEC cycle and a low rst silences every strobe immediately.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis would infer a latch.
    InsRead    = 1'b0;
    PCnext     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    ALUSrc     = 1'b0;
    RegWrite   = 1'b0;
    outEn      = 1'b0;
    RegDst     = 2'b00;
    PCSrc      = 2'b00;
    MemtoReg   = 2'b00;
    ALUControl = 3'b000;
    halted     = 1'b0;
    if (rst) begin
      unique case (state)
        FETCH:  InsRead = 1'b1;
        DECODE: ;
        EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              ALUControl = funct;
              RegDst     = 2'b01;
              RegWrite   = 1'b1;
              PCnext     = 1'b1;
            end
            OP_ADDI: begin
              ALUSrc   = 1'b1;
              RegWrite = 1'b1;
              PCnext   = 1'b1;
            end
            OP_LW, OP_SW: ALUSrc = 1'b1;
            OP_BEQ, OP_BNE: begin
              ALUControl = 3'b001;
              PCnext     = 1'b1;
              if ((opcode == OP_BEQ) == zero_flag) PCSrc = 2'b01;
            end
            OP_J: begin
              PCSrc  = 2'b10;
              PCnext = 1'b1;
            end
            OP_JR: begin
              PCSrc  = 2'b11;
              PCnext = 1'b1;
            end
            OP_JAL: begin
              PCSrc    = 2'b10;
              RegDst   = 2'b10;
              MemtoReg = 2'b10;
              RegWrite = 1'b1;
              PCnext   = 1'b1;
            end
            OP_IN: begin
              MemtoReg = 2'b11;
              RegWrite = 1'b1;
              PCnext   = 1'b1;
            end
            OP_OUT: begin
              outEn  = 1'b1;
              PCnext = 1'b1;
            end
            default: PCnext = 1'b1;
          endcase
        end
        MEM: begin
          ALUSrc = 1'b1;
          if (opcode == OP_SW) begin
            MemWrite = 1'b1;
            PCnext   = 1'b1;
          end else begin
            MemRead = 1'b1;
          end
        end
        WB: begin
          ALUSrc   = 1'b1;
          MemtoReg = 2'b01;
          RegWrite = 1'b1;
          PCnext   = 1'b1;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

  // State sequencing and retirement counting.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      state   <= FETCH;
      retired <= 16'h0000;
    end else begin
      if (PCnext) retired <= retired + 16'd1;
      case (state)
        FETCH:   state <= DECODE;
        DECODE:  state <= (opcode == OP_HALT) ? HALT : EXEC;
        EXEC:    state <= (opcode == OP_LW || opcode == OP_SW) ? MEM : FETCH;
        MEM:     state <= (opcode == OP_SW) ? FETCH : WB;
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed-vector bench for mips_control_unit. Inputs change and outputs are
// sampled just after the falling edge, well away from the rising edge.
module tb_mips_control_unit;

  // Snapshot of every control output, MSB first as listed.
  typedef struct packed {
    logic       ins_read;
    logic       pc_next;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       out_en;
    logic [1:0] reg_dst;
    logic [1:0] pc_src;
    logic [1:0] mem_to_reg;
    logic [2:0] alu_ctl;
    logic       halted;
  } ctl_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        zf;
    ctl_t        exec;
  } op_t;

  localparam ctl_t C_FETCH = 17'h10000;
  localparam ctl_t C_IDLE  = 17'h00000;
  localparam ctl_t C_HALT  = 17'h00001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        zero_flag = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic        InsRead, PCnext, MemRead, MemWrite, ALUSrc, RegWrite, outEn, halted;
  logic [1:0]  RegDst, PCSrc, MemtoReg;
  logic [2:0]  ALUControl;
  logic [15:0] retired;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_ret = 16'h0000;

  always #5 clk = ~clk;

  mips_control_unit #(.BUS_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .instruction(instruction),
    .zero_flag  (zero_flag),
    .InsRead    (InsRead),
    .PCnext     (PCnext),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .ALUSrc     (ALUSrc),
    .RegWrite   (RegWrite),
    .outEn      (outEn),
    .RegDst     (RegDst),
    .PCSrc      (PCSrc),
    .MemtoReg   (MemtoReg),
    .ALUControl (ALUControl),
    .halted     (halted),
    .retired    (retired)
  );

  function automatic ctl_t mk(input logic ir, input logic pn, input logic mr,
                              input logic mw, input logic as, input logic rw,
                              input logic oe, input logic [1:0] rd,
                              input logic [1:0] ps, input logic [1:0] mtr,
                              input logic [2:0] alu, input logic h);
    return {ir, pn, mr, mw, as, rw, oe, rd, ps, mtr, alu, h};
  endfunction

  function automatic ctl_t obs();
    return {InsRead, PCnext, MemRead, MemWrite, ALUSrc, RegWrite, outEn,
            RegDst, PCSrc, MemtoReg, ALUControl, halted};
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    instruction = 16'h0298;
    next_cycle();
    next_cycle();
    n_cmp++;
    if (obs() !== C_IDLE) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected %h", obs(), C_IDLE);
    end
    n_cmp++;
    if (retired !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_retired: got %h expected 0000", retired);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== C_FETCH) begin
      n_bad++;
      $display("FAIL reset_release_fetch: got %h expected %h", obs(), C_FETCH);
    end
    exp_ret = 16'h0000;
  endtask

  // Three-cycle instructions from a table: FETCH, DECODE, EXEC, then retired.
  task automatic run_table(input op_t ops[$]);
    foreach (ops[k]) begin
      instruction = ops[k].instr;
      zero_flag   = ops[k].zf;
      #1;
      n_cmp++;
      if (obs() !== C_FETCH) begin
        n_bad++;
        $display("FAIL %s_fetch: got %h expected %h", ops[k].name, obs(), C_FETCH);
      end
      next_cycle();
      n_cmp++;
      if (obs() !== C_IDLE) begin
        n_bad++;
        $display("FAIL %s_decode: got %h expected %h", ops[k].name, obs(), C_IDLE);
      end
      next_cycle();
      n_cmp++;
      if (obs() !== ops[k].exec) begin
        n_bad++;
        $display("FAIL %s_exec: got %h expected %h", ops[k].name, obs(), ops[k].exec);
      end
      next_cycle();
      exp_ret = exp_ret + 16'd1;
      n_cmp++;
      if (retired !== exp_ret) begin
        n_bad++;
        $display("FAIL %s_retired: got %h expected %h", ops[k].name, retired, exp_ret);
      end
    end
  endtask

  task automatic test_add();
    op_t ops[$];
    ops.push_back('{"add_r3_r1_r2", 16'h0298, 1'b0, mk(0,1,0,0,0,1,0,2'b01,0,0,3'b000,0)});
    run_table(ops);
  endtask

  task automatic test_mem_op(input string name, input logic [15:0] instr,
                             input logic is_load);
    ctl_t seq[$];
    seq.push_back(C_FETCH);
    seq.push_back(C_IDLE);
    seq.push_back(mk(0,0,0,0,1,0,0,0,0,0,0,0));
    if (is_load) begin
      seq.push_back(mk(0,0,1,0,1,0,0,0,0,0,0,0));
      seq.push_back(mk(0,1,0,0,1,1,0,0,0,2'b01,0,0));
    end else begin
      seq.push_back(mk(0,1,0,1,1,0,0,0,0,0,0,0));
    end
    instruction = instr;
    zero_flag   = 1'b0;
    #1;
    foreach (seq[i]) begin
      if (i > 0) next_cycle();
      n_cmp++;
      if (obs() !== seq[i]) begin
        n_bad++;
        $display("FAIL %s_cycle%0d: got %h expected %h", name, i + 1, obs(), seq[i]);
      end
    end
    next_cycle();
    exp_ret = exp_ret + 16'd1;
    n_cmp++;
    if (retired !== exp_ret || obs() !== C_FETCH) begin
      n_bad++;
      $display("FAIL %s_done: got retired %h ctl %h expected retired %h ctl %h",
               name, retired, obs(), exp_ret, C_FETCH);
    end
  endtask

  task automatic test_lw();
    test_mem_op("lw", 16'h2285, 1'b1);
  endtask

  task automatic test_sw();
    test_mem_op("sw", 16'h3285, 1'b0);
  endtask

  task automatic test_branch();
    op_t ops[$];
    ops.push_back('{"beq_taken",    16'h4123, 1'b1, mk(0,1,0,0,0,0,0,0,2'b01,0,3'b001,0)});
    ops.push_back('{"bne_nottaken", 16'h5123, 1'b1, mk(0,1,0,0,0,0,0,0,2'b00,0,3'b001,0)});
    ops.push_back('{"beq_nottaken", 16'h4000, 1'b0, mk(0,1,0,0,0,0,0,0,2'b00,0,3'b001,0)});
    ops.push_back('{"bne_taken",    16'h5000, 1'b0, mk(0,1,0,0,0,0,0,0,2'b01,0,3'b001,0)});
    run_table(ops);
  endtask

  task automatic test_jal();
    op_t ops[$];
    ops.push_back('{"jal", 16'hA010, 1'b0, mk(0,1,0,0,0,1,0,2'b10,2'b10,2'b10,0,0)});
    run_table(ops);
  endtask

  task automatic test_other_ops();
    op_t ops[$];
    ops.push_back('{"addi",     16'h1234, 1'b0, mk(0,1,0,0,1,1,0,0,0,0,3'b000,0)});
    ops.push_back('{"rtype_f5", 16'h0295, 1'b1, mk(0,1,0,0,0,1,0,2'b01,0,0,3'b101,0)});
    ops.push_back('{"j",        16'h6abc, 1'b0, mk(0,1,0,0,0,0,0,0,2'b10,0,0,0)});
    ops.push_back('{"jr",       16'h7001, 1'b1, mk(0,1,0,0,0,0,0,0,2'b11,0,0,0)});
    ops.push_back('{"in",       16'h8200, 1'b0, mk(0,1,0,0,0,1,0,0,0,2'b11,0,0)});
    ops.push_back('{"out",      16'h9200, 1'b0, mk(0,1,0,0,0,0,1,0,0,0,0,0)});
    ops.push_back('{"undef_b",  16'hB007, 1'b1, mk(0,1,0,0,0,0,0,0,0,0,0,0)});
    ops.push_back('{"undef_e",  16'hE000, 1'b0, mk(0,1,0,0,0,0,0,0,0,0,0,0)});
    run_table(ops);
  endtask

  task automatic test_halt();
    int bad_cycles;
    instruction = 16'hF000;
    zero_flag   = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== C_FETCH) begin
      n_bad++;
      $display("FAIL halt_fetch: got %h expected %h", obs(), C_FETCH);
    end
    next_cycle();
    n_cmp++;
    if (obs() !== C_IDLE) begin
      n_bad++;
      $display("FAIL halt_decode: got %h expected %h", obs(), C_IDLE);
    end
    bad_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      if (obs() !== C_HALT) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin
      n_bad++;
      $display("FAIL halt_hold: got %0d cycles off HALT pattern expected 0 (last ctl %h)",
               bad_cycles, obs());
    end
    n_cmp++;
    if (retired !== exp_ret) begin
      n_bad++;
      $display("FAIL halt_retired: got %h expected %h", retired, exp_ret);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== C_IDLE) begin
      n_bad++;
      $display("FAIL halt_rst_outputs: got %h expected %h", obs(), C_IDLE);
    end
    next_cycle();
    rst = 1'b1;
    #1;
    exp_ret = 16'h0000;
    n_cmp++;
    if (retired !== exp_ret || obs() !== C_FETCH) begin
      n_bad++;
      $display("FAIL halt_restart: got retired %h ctl %h expected retired %h ctl %h",
               retired, obs(), exp_ret, C_FETCH);
    end
  endtask

  task automatic test_reset_mid_lw();
    op_t ops[$];
    // Preset the counter to its top value while idle in FETCH.
    force dut.retired = 16'hFFFF;
    #1;
    release dut.retired;
    exp_ret = 16'hFFFF;
    ops.push_back('{"wrap_add", 16'h0298, 1'b0, mk(0,1,0,0,0,1,0,2'b01,0,0,3'b000,0)});
    run_table(ops);
    n_cmp++;
    if (retired !== 16'h0000) begin
      n_bad++;
      $display("FAIL retired_wrap: got %h expected 0000", retired);
    end
    instruction = 16'h2285;
    next_cycle();
    next_cycle();
    next_cycle();
    n_cmp++;
    if (obs() !== mk(0,0,1,0,1,0,0,0,0,0,0,0)) begin
      n_bad++;
      $display("FAIL midlw_mem: got %h expected %h", obs(), mk(0,0,1,0,1,0,0,0,0,0,0,0));
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== C_IDLE) begin
      n_bad++;
      $display("FAIL midlw_rst_outputs: got %h expected %h", obs(), C_IDLE);
    end
    next_cycle();
    n_cmp++;
    if (obs() !== C_IDLE || retired !== 16'h0000) begin
      n_bad++;
      $display("FAIL midlw_no_wb: got ctl %h retired %h expected ctl %h retired 0000",
               obs(), retired, C_IDLE);
    end
    rst = 1'b1;
    exp_ret = 16'h0000;
    ops.delete();
    ops.push_back('{"restart_add", 16'h0298, 1'b0, mk(0,1,0,0,0,1,0,2'b01,0,0,3'b000,0)});
    run_table(ops);
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_branch();
    test_jal();
    test_other_ops();
    test_halt();
    test_reset_mid_lw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_control_unit.md
MIPS_CONTROL_UNIT -- requirements
Module: mips_control_unit

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, meaning instruction width in bits.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-004 SHALL have port instruction, input, BUS_WIDTH bits: current instruction; opcode=[15:12], funct=[2:0].
REQ-005 SHALL have port zero_flag, input, 1 bit: ALU zero result.
REQ-006 SHALL have ports InsRead, PCnext, MemRead, MemWrite, ALUSrc, RegWrite and outEn, each output, 1 bit: datapath strobes and selects.
REQ-007 SHALL have ports RegDst, PCSrc and MemtoReg, each output, 2 bits: datapath mux selects.
REQ-008 SHALL have port ALUControl, output, 3 bits: ALU operation.
REQ-009 SHALL have port halted, output, 1 bit: high while in HALT.
REQ-010 SHALL have port retired, output, 16 bits: count of completed instructions.

Function
REQ-011 SHALL implement a five-state FSM: FETCH, DECODE, EXEC, MEM, WB, plus a sixth terminal state, HALT.
REQ-012 SHALL drive every output low in every state unless it is listed as asserted here.
REQ-013 SHALL, in FETCH: InsRead=1; next state DECODE; instruction is valid from DECODE onward.
REQ-014 SHALL, in DECODE: assert no outputs; next state EXEC, or HALT when opcode=1111.
REQ-015 SHALL, in EXEC for R-type (0000): ALUControl=funct, RegDst=01, MemtoReg=00, RegWrite=1, PCnext=1, PCSrc=00; next state FETCH.
REQ-016 SHALL, in EXEC for ADDI (0001): ALUSrc=1, ALUControl=000, RegDst=00, RegWrite=1, PCnext=1, PCSrc=00; next state FETCH.
REQ-017 SHALL, in EXEC for LW (0010) and SW (0011): ALUSrc=1, ALUControl=000; next state MEM.
REQ-018 SHALL, in EXEC for BEQ (0100) and BNE (0101): ALUControl=001, PCnext=1; PCSrc=01 when the branch is taken (BEQ: zero_flag=1; BNE: zero_flag=0), else PCSrc=00; zero_flag is sampled combinationally; next state FETCH.
REQ-019 SHALL, in EXEC for J (0110): PCSrc=10, PCnext=1; for JR (0111): PCSrc=11, PCnext=1; next state FETCH.
REQ-020 SHALL, in EXEC for JAL (1010): PCSrc=10, PCnext=1, RegDst=10, MemtoReg=10, RegWrite=1; link value is the JAL's own address; next state FETCH.
REQ-021 SHALL, in EXEC for IN (1000): MemtoReg=11, RegDst=00, RegWrite=1, PCnext=1; next state FETCH.
REQ-022 SHALL, in EXEC for OUT (1001): outEn=1, PCnext=1; next state FETCH.
REQ-023 SHALL, in EXEC for any undefined opcode: PCnext=1, PCSrc=00 (NOP); next state FETCH.
REQ-024 SHALL, in MEM: hold ALUSrc=1, ALUControl=000.
REQ-025 SHALL, in MEM for SW: MemWrite=1, PCnext=1; next state FETCH.
REQ-026 SHALL, in MEM for LW: MemRead=1; next state WB.
REQ-027 SHALL, in WB: hold ALUSrc=1, ALUControl=000; assert MemtoReg=01, RegDst=00, RegWrite=1, PCnext=1; next state FETCH.
REQ-028 SHALL take 3 cycles per instruction for ALU, branch, jump, IN and OUT; 4 cycles for SW; 5 cycles for LW.
REQ-029 SHALL assert PCnext exactly once per instruction, and only in the final cycle of that instruction.
REQ-030 SHALL, in HALT: assert halted=1; assert no other outputs; stay in HALT until reset.
REQ-031 SHALL increment retired by 1 on each clock edge at which PCnext=1.
REQ-032 SHALL let retired wrap from 0xFFFF to 0x0000.
REQ-033 SHALL NOT count HALT as a retired instruction.

Reset
REQ-034 SHALL, when rst=0 at a rising edge: go to FETCH and set retired=0x0000.
REQ-035 SHALL keep all control outputs at 0 while rst=0; this overrides every state, including the middle of LW/SW and HALT.
REQ-036 SHALL, on the first edge after rst returns to 1: be in FETCH with InsRead=1.

Verification
REQ-037 SHALL cover: reset release, then ADD r3,r1,r2 (0x0298) -> InsRead, idle, then RegWrite=1 with RegDst=01, ALUControl=000 and PCnext=1 on cycle 3; retired=1.
REQ-038 SHALL cover: LW (0x2285) -> MemRead=1 only on cycle 4; RegWrite=1 with MemtoReg=01 and PCnext=1 only on cycle 5.
REQ-039 SHALL cover: BEQ with zero_flag=1 -> PCSrc=01; then BNE with zero_flag=1 -> PCSrc=00; PCnext=1 in EXEC of both.
REQ-040 SHALL cover: JAL 0xA010 -> PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1 in one cycle.
REQ-041 SHALL cover: HALT 0xF000 -> halted=1 and no further PCnext for 20 cycles; then rst=0 for 1 cycle -> FETCH, retired=0.
REQ-042 SHALL cover: rst=0 during LW MEM state -> no WB RegWrite and no PCnext; restart in FETCH; retired preset to 0xFFFF plus one retirement -> 0x0000.
